// File: rtl/instruction_decoder_pkg.sv
// rtl/instruction_decoder_pkg.sv - ISA field widths, positions and shared field types
package instruction_decoder_pkg;

  localparam int INSTR_W   = 16;
  localparam int OPCODE_W  = 5;
  localparam int REG_IDX_W = 3;
  localparam int IMM_W     = 8;

  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 11;
  localparam int RD_MSB     = 10;
  localparam int RD_LSB     = 8;
  localparam int RS_MSB     = 7;
  localparam int RS_LSB     = 5;
  localparam int K_MSB      = 7;
  localparam int K_LSB      = 0;

  typedef logic [OPCODE_W-1:0]  opcode_t;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [IMM_W-1:0]     imm_t;
  typedef logic [INSTR_W-1:0]   instr_t;

  typedef struct packed {
    opcode_t  opcode;
    reg_idx_t rd;
    reg_idx_t rs;
    imm_t     k;
  } fields_t;

  // rs deliberately aliases the top bits of k; both come from the same word.
  function automatic fields_t decode_fields(input instr_t instr);
    fields_t f;
    f.opcode = instr[OPCODE_MSB:OPCODE_LSB];
    f.rd     = instr[RD_MSB:RD_LSB];
    f.rs     = instr[RS_MSB:RS_LSB];
    f.k      = instr[K_MSB:K_LSB];
    return f;
  endfunction

endpackage

// File: rtl/instruction_decoder.sv
// rtl/instruction_decoder.sv - registered opcode/rd/rs/k field extraction
module instruction_decoder
  import instruction_decoder_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [INSTR_W-1:0]   instruction,
  output logic [OPCODE_W-1:0]  opcode,
  output logic [REG_IDX_W-1:0] rd,
  output logic [REG_IDX_W-1:0] rs,
  output logic [IMM_W-1:0]     k
);

  fields_t fields_d;
  fields_t fields_q;

  always_comb begin
    fields_d = decode_fields(instruction);
  end

  // Reset wins over capture so an in-flight word is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      fields_q <= '0;
    end else begin
      fields_q <= fields_d;
    end
  end

  assign opcode = fields_q.opcode;
  assign rd     = fields_q.rd;
  assign rs     = fields_q.rs;
  assign k      = fields_q.k;

endmodule

// File: tb/tb_instruction_decoder.sv
// tb/tb_instruction_decoder.sv - scoreboard bench for instruction_decoder
module tb_instruction_decoder;

  typedef struct {
    logic [4:0] op;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [7:0] k;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] instruction = 16'hFFFF;
  logic [4:0]  opcode;
  logic [2:0]  rd;
  logic [2:0]  rs;
  logic [7:0]  k;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  instruction_decoder dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .opcode      (opcode),
    .rd          (rd),
    .rs          (rs),
    .k           (k)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [4:0] op, input logic [2:0] d, input logic [2:0] s,
                              input logic [7:0] kk);
    exp_t e;
    e.op = op; e.rd = d; e.rs = s; e.k = kk;
    return e;
  endfunction

  // Independent reference: arithmetic shifts/masks instead of bit slices.
  function automatic exp_t model(input logic [15:0] ins);
    int v;
    v = int'(ins);
    return mk(5'((v >> 11) & 31), 3'((v >> 8) & 7), 3'((v / 32) % 8), 8'(v % 256));
  endfunction

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check_val({tag, "_sb_empty"}, 8'd1, 8'd0);
      return;
    end
    e = sb.pop_front();
    check_val({tag, "_opcode"}, {3'b0, opcode}, {3'b0, e.op});
    check_val({tag, "_rd"},     {5'b0, rd},     {5'b0, e.rd});
    check_val({tag, "_rs"},     {5'b0, rs},     {5'b0, e.rs});
    check_val({tag, "_k"},      k,              e.k);
  endtask

  task automatic step(input string tag, input logic r, input logic [15:0] ins, input exp_t e);
    @(negedge clk);
    rst = r;
    instruction = ins;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_out(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r;
    step("rst0", 1'b1, 16'hFFFF, mk(5'h00, 3'd0, 3'd0, 8'h00));
    step("rst1", 1'b1, 16'hFFFF, mk(5'h00, 3'd0, 3'd0, 8'h00));
    step("i0000", 1'b0, 16'h0000, mk(5'h00, 3'd0, 3'd0, 8'h00));
    step("i0001", 1'b0, 16'h0001, mk(5'h00, 3'd0, 3'd0, 8'h01));
    step("i60FF", 1'b0, 16'h60FF, mk(5'h0C, 3'd0, 3'd7, 8'hFF));
    step("i61FE", 1'b0, 16'h61FE, mk(5'h0C, 3'd1, 3'd7, 8'hFE));
    step("i62FD", 1'b0, 16'h62FD, mk(5'h0C, 3'd2, 3'd7, 8'hFD));
    step("i4101", 1'b0, 16'h4101, mk(5'h08, 3'd1, 3'd0, 8'h01));

    // Mid-cycle change must not reach the outputs before the next edge.
    #3;
    instruction = 16'hF8E5;
    #1;
    sb.push_back(mk(5'h08, 3'd1, 3'd0, 8'h01));
    compare_out("hold4101");
    sb.push_back(mk(5'h1F, 3'd0, 3'd7, 8'hE5));
    @(posedge clk);
    #1;
    compare_out("iF8E5");

    step("rst_mid", 1'b1, 16'h62FD, mk(5'h00, 3'd0, 3'd0, 8'h00));
    step("post_rst", 1'b0, 16'h62FD, mk(5'h0C, 3'd2, 3'd7, 8'hFD));
    step("op_max", 1'b0, 16'hFFFF, mk(5'h1F, 3'd7, 3'd7, 8'hFF));

    for (int i = 0; i < 24; i++) begin
      r = 16'($urandom);
      step("rand", 1'b0, r, model(r));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
